// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CDB widths, packet type and source encoding
package cpu_pkg;

    localparam int RoB_WIDTH  = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    // One common-data-bus result as it travels through the arbiter queues
    typedef struct packed {
        logic [RoB_WIDTH-1:0]  rob_index;
        logic [DATA_WIDTH-1:0] value;
        logic [ADDR_WIDTH-1:0] next_pc;
    } cdb_pkt_t;

    // Which producer owns a grant; reset value LSB lets RS win the first tie
    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_t;

endpackage

// File: rtl/arb_queue.sv
// rtl/arb_queue.sv - small circular FIFO of cdb_pkt_t with push/pop/flush/count
module arb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  cdb_pkt_t         push_pkt,
    input  logic             pop,
    input  logic             flush,
    output cdb_pkt_t         head_pkt,
    output logic [CNT_W-1:0] count
);

    cdb_pkt_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow locally; flush beats both
    assign do_push  = push && (count != CNT_W'(DEPTH)) && !flush;
    assign do_pop   = pop && (count != '0) && !flush;
    assign head_pkt = mem[rd_ptr];

    // Storage array: data only, validity is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_pkt;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - RS/LSB result arbiter onto the CDB (optional CDB_ARB_PERF_CNT_EN counters)
module cdb_arbiter #(
    parameter int RoB_WIDTH   = cpu_pkg::RoB_WIDTH,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                 Sys_clk,
    input  logic                 Sys_rst,
    input  logic                 Sys_rdy,
    input  logic                 RSARB_en,
    input  logic [RoB_WIDTH-1:0] RSARB_RoB_index,
    input  logic [31:0]          RSARB_value,
    input  logic [31:0]          RSARB_next_pc,
    output logic                 ARBRS_ready,
    input  logic                 LSBARB_en,
    input  logic [RoB_WIDTH-1:0] LSBARB_RoB_index,
    input  logic [31:0]          LSBARB_value,
    output logic                 ARBLSB_ready,
    input  logic                 RoBARB_flush,
`ifdef CDB_ARB_PERF_CNT_EN
    output logic [31:0]          ARB_conflict_cnt,
    output logic [31:0]          ARB_stall_cnt,
`endif
    output logic                 ARBCDB_en,
    output logic [RoB_WIDTH-1:0] ARBCDB_RoB_index,
    output logic [31:0]          ARBCDB_value,
    output logic [31:0]          ARBCDB_next_pc,
    output logic                 ARBCDB_from_lsb
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    cpu_pkg::cdb_pkt_t rs_in_pkt;
    cpu_pkg::cdb_pkt_t lsb_in_pkt;
    cpu_pkg::cdb_pkt_t rs_head;
    cpu_pkg::cdb_pkt_t lsb_head;
    cpu_pkg::cdb_pkt_t grant_pkt;
    cpu_pkg::cdb_src_t grant_src;
    cpu_pkg::cdb_src_t last_grant;

    logic [CNT_W-1:0] rs_count;
    logic [CNT_W-1:0] lsb_count;
    logic             rs_pending;
    logic             lsb_pending;
    logic             rst_done;
    logic             active;
    logic             q_flush;
    logic             rs_push;
    logic             lsb_push;
    logic             rs_pop;
    logic             lsb_pop;
    logic             grant_valid;

    // A frozen block ignores flush; ready is held low until the first edge out of reset
    assign active       = Sys_rdy && !RoBARB_flush;
    assign q_flush      = Sys_rdy && RoBARB_flush;
    assign rs_pending   = (rs_count != '0);
    assign lsb_pending  = (lsb_count != '0);
    assign ARBRS_ready  = rst_done && Sys_rdy && (rs_count != CNT_W'(QUEUE_DEPTH));
    assign ARBLSB_ready = rst_done && Sys_rdy && (lsb_count != CNT_W'(QUEUE_DEPTH));
    assign rs_push      = RSARB_en && ARBRS_ready && !RoBARB_flush;
    assign lsb_push     = LSBARB_en && ARBLSB_ready && !RoBARB_flush;

    // LSB results never redirect fetch, so their next_pc travels as zero
    assign rs_in_pkt  = '{rob_index: RSARB_RoB_index, value: RSARB_value, next_pc: RSARB_next_pc};
    assign lsb_in_pkt = '{rob_index: LSBARB_RoB_index, value: LSBARB_value, next_pc: '0};

    // Grant: a lone pending queue wins outright, a tie goes to the source not granted last
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = cpu_pkg::SRC_LSB;
        if (active && (rs_pending || lsb_pending)) begin
            grant_valid = 1'b1;
            if (rs_pending && lsb_pending) begin
                grant_src = (last_grant == cpu_pkg::SRC_LSB) ? cpu_pkg::SRC_RS : cpu_pkg::SRC_LSB;
            end else if (rs_pending) begin
                grant_src = cpu_pkg::SRC_RS;
            end else begin
                grant_src = cpu_pkg::SRC_LSB;
            end
        end
    end

    assign rs_pop    = grant_valid && (grant_src == cpu_pkg::SRC_RS);
    assign lsb_pop   = grant_valid && (grant_src == cpu_pkg::SRC_LSB);
    assign grant_pkt = (grant_src == cpu_pkg::SRC_RS) ? rs_head : lsb_head;

    arb_queue #(.DEPTH(QUEUE_DEPTH)) u_rs_queue (
        .clk      (Sys_clk),
        .rst_n    (Sys_rst),
        .push     (rs_push),
        .push_pkt (rs_in_pkt),
        .pop      (rs_pop),
        .flush    (q_flush),
        .head_pkt (rs_head),
        .count    (rs_count)
    );

    arb_queue #(.DEPTH(QUEUE_DEPTH)) u_lsb_queue (
        .clk      (Sys_clk),
        .rst_n    (Sys_rst),
        .push     (lsb_push),
        .push_pkt (lsb_in_pkt),
        .pop      (lsb_pop),
        .flush    (q_flush),
        .head_pkt (lsb_head),
        .count    (lsb_count)
    );

    // Marks the first edge after reset release so ready rises there, not during reset
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // CDB output registers and round-robin history; everything holds while Sys_rdy is low
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            ARBCDB_en        <= 1'b0;
            ARBCDB_RoB_index <= '0;
            ARBCDB_value     <= '0;
            ARBCDB_next_pc   <= '0;
            ARBCDB_from_lsb  <= 1'b0;
            last_grant       <= cpu_pkg::SRC_LSB;
        end else if (Sys_rdy) begin
            if (RoBARB_flush) begin
                ARBCDB_en  <= 1'b0;
                last_grant <= cpu_pkg::SRC_LSB;
            end else if (grant_valid) begin
                ARBCDB_en        <= 1'b1;
                ARBCDB_RoB_index <= grant_pkt.rob_index;
                ARBCDB_value     <= grant_pkt.value;
                ARBCDB_next_pc   <= grant_pkt.next_pc;
                ARBCDB_from_lsb  <= (grant_src == cpu_pkg::SRC_LSB);
                last_grant       <= grant_src;
            end else begin
                ARBCDB_en <= 1'b0;
            end
        end
    end

`ifdef CDB_ARB_PERF_CNT_EN
    logic conflict_evt;
    logic stall_evt;

    assign conflict_evt = grant_valid && rs_pending && lsb_pending;
    assign stall_evt    = Sys_rdy && ((RSARB_en && !ARBRS_ready) || (LSBARB_en && !ARBLSB_ready));

    // Saturating event counters; flush deliberately does not clear them
    always_ff @(posedge Sys_clk or negedge Sys_rst) begin
        if (!Sys_rst) begin
            ARB_conflict_cnt <= '0;
            ARB_stall_cnt    <= '0;
        end else begin
            if (conflict_evt && (ARB_conflict_cnt != '1)) begin
                ARB_conflict_cnt <= ARB_conflict_cnt + 32'd1;
            end
            if (stall_evt && (ARB_stall_cnt != '1)) begin
                ARB_stall_cnt <= ARB_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
